// File: rtl/mips_memory_responder.sv
// mips_memory_responder: serialised load/store responder over a word array; misalign trap via MIPS_MEMORY_RESPONDER_MISALIGN_TRAP_EN
module mips_memory_responder #(
  parameter int ADDR_L = 64,
  localparam int ADDR_W = $clog2(ADDR_L)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic              req_wren,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_data,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_error
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RSP = 2'd3;
  localparam logic [1:0] SZ_NONE = 2'd0, SZ_BYTE = 2'd1, SZ_HALF = 2'd2, SZ_WORD = 2'd3;
  logic [1:0] state;
  logic [ADDR_W-1:0] idx;
  logic [1:0] lane, size, in_lane;
  logic wren, sgn, acc, mis;
  logic [31:0] data, rdq, shifted, ld, mask, wdata;
  logic [31:0] mem [ADDR_L];
  assign req_ready = state == IDLE;
  assign resp_valid = state == RSP;
  assign acc = req_valid & req_ready;
  // sub-word accesses snap to their natural alignment when not trapping
  assign in_lane = req_size == SZ_WORD ? 2'b00 : req_size == SZ_HALF ? {req_addr[1], 1'b0} : req_addr[1:0];
`ifdef MIPS_MEMORY_RESPONDER_MISALIGN_TRAP_EN
  assign mis = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  // load extraction is taken straight from the array so the result is ready as RD ends
  always_comb begin
    shifted = mem[idx] >> {lane, 3'b000};
    ld = size == SZ_BYTE ? {{24{sgn & shifted[7]}}, shifted[7:0]} :
         size == SZ_HALF ? {{16{sgn & shifted[15]}}, shifted[15:0]} : shifted;
    mask = (size == SZ_BYTE ? 32'h0000_00FF : 32'h0000_FFFF) << {lane, 3'b000};
    wdata = size == SZ_WORD ? data : (rdq & ~mask) | ((data << {lane, 3'b000}) & mask);
  end
  // request sequencing; response fields are loaded only on entry to RSP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      lane <= '0;
      size <= '0;
      wren <= 1'b0;
      sgn <= 1'b0;
      data <= '0;
      rdq <= '0;
      resp_data <= '0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          idx <= req_addr[ADDR_W+1:2];
          lane <= in_lane;
          size <= req_size;
          wren <= req_wren;
          sgn <= req_signed;
          data <= req_data;
          if (req_size == SZ_NONE || mis) begin
            resp_data <= '0;
            resp_error <= mis;
          end
          state <= (req_size == SZ_NONE || mis) ? RSP : (req_wren && req_size == SZ_WORD) ? WR : RD;
        end
        RD: begin
          rdq <= mem[idx];
          if (!wren) begin
            resp_data <= ld;
            resp_error <= 1'b0;
          end
          state <= wren ? WR : RSP;
        end
        WR: begin
          resp_data <= '0;
          resp_error <= 1'b0;
          state <= RSP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // storage has no reset; a reset before the WR edge leaves the word untouched
  always_ff @(posedge clk) begin
    if (state == WR) mem[idx] <= wdata;
  end
endmodule

// File: tb/tb_mips_memory_responder.sv
// tb_mips_memory_responder: random and directed requests checked against a byte-array memory model
module tb_mips_memory_responder;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_wren = 0, req_signed = 0;
  logic req_ready, resp_valid, resp_error;
  logic [7:0] req_addr = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_data = 0, resp_data;
  int tests = 0, fails = 0, cyc = 0, exp_at = -1;
  logic [31:0] exp_data = 0;
  logic exp_err = 0;
  logic [7:0] mb [256];

  mips_memory_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wren(req_wren), .req_size(req_size),
    .req_signed(req_signed), .req_data(req_data), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_error(resp_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // every cycle: a response must appear exactly when the model says, with the model's payload
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (resp_valid !== (cyc == exp_at)) begin
        fails++;
        $display("FAIL resp_valid cyc=%0d got=%b want=%b", cyc, resp_valid, cyc == exp_at);
      end
      if (resp_valid) begin
        tests++;
        if (resp_data !== exp_data || resp_error !== exp_err) begin
          fails++;
          $display("FAIL resp_payload cyc=%0d got=%h/%b want=%h/%b", cyc, resp_data, resp_error, exp_data, exp_err);
        end
      end
    end
  end

  // byte-level reference: aligned access of n bytes, little-endian
  task automatic model(input logic w, input logic [1:0] sz, input logic [7:0] ad, input logic sg,
                       input logic [31:0] d, output logic [31:0] ed, output logic ee, output int lat);
    int n;
    logic [7:0] a;
    ed = 0; ee = 0;
    if (sz == 0) begin lat = 1; return; end
`ifdef MIPS_MEMORY_RESPONDER_MISALIGN_TRAP_EN
    if ((sz == 2 && ad[0]) || (sz == 3 && ad[1:0] != 0)) begin ee = 1; lat = 1; return; end
`endif
    n = sz == 1 ? 1 : sz == 2 ? 2 : 4;
    a = ad & ~8'(n - 1);
    if (w) begin
      for (int i = 0; i < n; i++) mb[8'(a + i)] = d[8*i +: 8];
      lat = n == 4 ? 2 : 3;
    end else begin
      for (int i = 0; i < n; i++) ed = ed | (32'(mb[8'(a + i)]) << (8 * i));
      if (sg && n < 4 && ed[8*n-1]) ed = ed | (32'hFFFF_FFFF << (8 * n));
      lat = 2;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (!req_ready) begin fails++; $display("FAIL ready_timeout got=0 want=1"); end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic [7:0] ad, input logic sg,
                        input logic [31:0] d, output logic [31:0] got, output logic gerr);
    int lat;
    logic [31:0] ed;
    logic ee;
    bit seen = 0;
    wait_ready();
    model(w, sz, ad, sg, d, ed, ee, lat);
    exp_data = ed; exp_err = ee; exp_at = cyc + lat;
    req_wren = w; req_size = sz; req_addr = ad; req_signed = sg; req_data = d; req_valid = 1;
    @(posedge clk);
    #1;
    req_valid = 0; req_addr = 8'($urandom); req_data = $urandom; req_size = 2'($urandom);
    req_wren = 1'($urandom); req_signed = 1'($urandom);
    got = 'x; gerr = 'x;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = resp_data; gerr = resp_error; seen = 1; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL resp_timeout got=none want=resp"); end
  endtask

  initial begin
    logic [31:0] g;
    logic e;
    repeat (3) @(negedge clk);
    chk("reset_resp_valid", 32'(resp_valid), 0);
    chk("reset_resp_data", resp_data, 0);
    chk("reset_resp_error", 32'(resp_error), 0);
    chk("reset_ready", 32'(req_ready), 1);
    rst = 0;
    for (int i = 0; i < 64; i++) do_req(1, 3, 8'(i * 4), 0, $urandom, g, e);
    do_req(1, 3, 8'h10, 0, 32'hDEADBEEF, g, e);  chk("word_store_ack", g, 0);
    do_req(0, 3, 8'h10, 0, 0, g, e);             chk("word_load", g, 32'hDEADBEEF);
    do_req(1, 1, 8'h11, 0, 32'h7A, g, e);        chk("byte_store_ack", g, 0);
    do_req(0, 3, 8'h10, 0, 0, g, e);             chk("byte_merge", g, 32'hDEAD7AEF);
    do_req(1, 3, 8'h20, 0, 32'h80FF7F01, g, e);
    do_req(0, 1, 8'h22, 1, 0, g, e);             chk("byte_sx", g, 32'hFFFFFFFF);
    do_req(0, 1, 8'h22, 0, 0, g, e);             chk("byte_zx", g, 32'h000000FF);
    do_req(0, 2, 8'h22, 1, 0, g, e);             chk("half_sx", g, 32'hFFFF80FF);
    do_req(0, 1, 8'h20, 1, 0, g, e);             chk("byte_pos", g, 32'h00000001);
    do_req(1, 3, 8'h30, 0, 32'h0BADF00D, g, e);
    do_req(1, 0, 8'h30, 0, 32'h55, g, e);        chk("none_data", g, 0);
    do_req(0, 3, 8'h30, 0, 0, g, e);             chk("none_no_write", g, 32'h0BADF00D);
    do_req(1, 3, 8'h00, 0, 32'h0000C3A5, g, e);
    do_req(0, 2, 8'h01, 1, 0, g, e);
`ifdef MIPS_MEMORY_RESPONDER_MISALIGN_TRAP_EN
    chk("misalign_err", 32'(e), 1);              chk("misalign_data", g, 0);
`else
    chk("misalign_err", 32'(e), 0);              chk("misalign_data", g, 32'hFFFFC3A5);
`endif
    do_req(1, 3, 8'h40, 0, 32'h12345678, g, e);
    wait_ready();
    exp_at = -1;
    req_wren = 1; req_size = 2; req_addr = 8'h42; req_signed = 0; req_data = 32'hABCD; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    #1 chk("rst_mid_valid", 32'(resp_valid), 0);
    repeat (2) @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 1);
    chk("rst_mid_data", resp_data, 0);
    rst = 0;
    do_req(0, 3, 8'h40, 0, 0, g, e);             chk("rst_abandon_wr", g, 32'h12345678);
    for (int i = 0; i < 400; i++)
      do_req(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), $urandom, g, e);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
